// File: rtl/ramb4_s1_s2_fifo_ctrl_if.sv
// Host-side handshake bundle for the 1-bit-in / 2-bit-out FIFO controller.
// master = producer/consumer side, slave = controller side.
//
// Signals:
//   WR_EN, WR_DATA : one-bit write request and data (master -> slave)
//   RD_REQ         : request for one 2-bit symbol (master -> slave)
//   RD_DATA        : symbol read back, first-written bit in [0] (slave -> master)
//   RD_VALID       : RD_DATA carries an accepted read (slave -> master)
interface ramb4_s1_s2_fifo_ctrl_if;
    logic       WR_EN;
    logic       WR_DATA;
    logic       RD_REQ;
    logic [1:0] RD_DATA;
    logic       RD_VALID;

    modport master (
        output WR_EN,
        output WR_DATA,
        output RD_REQ,
        input  RD_DATA,
        input  RD_VALID
    );

    modport slave (
        input  WR_EN,
        input  WR_DATA,
        input  RD_REQ,
        output RD_DATA,
        output RD_VALID
    );
endinterface

// File: rtl/ramb4_s1_s2_fifo_ctrl.sv
// FIFO controller that sequences one X_RAMB4_S1_S2 block RAM as a serial
// 1-bit write / 2-bit read width-converting buffer (4096 bits deep).
//
// Ports:
//   CLK, RST   : clock (also RAM CLKA/CLKB), synchronous active-high reset
//   FLUSH      : synchronous clear of pointers, level and sticky flags
//   host       : WR_EN/WR_DATA/RD_REQ in, RD_DATA/RD_VALID out
//   FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY : occupancy flags from LEVEL
//   OVERFLOW, UNDERFLOW : sticky error flags
//   LEVEL      : occupancy in bits, 0..4096
//   ADDRA, DIA, ENA, WEA, RSTA : RAM port A (serial write side)
//   ADDRB, ENB, WEB, RSTB, DOB : RAM port B (pair-wise read side)
module ramb4_s1_s2_fifo_ctrl #(
    parameter int AFULL_THRESH  = 4032,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         FLUSH,
    ramb4_s1_s2_fifo_ctrl_if.slave       host,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic                         ALMOST_FULL,
    output logic                         ALMOST_EMPTY,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW,
    output logic [12:0]                  LEVEL,
    output logic [11:0]                  ADDRA,
    output logic                         DIA,
    output logic                         ENA,
    output logic                         WEA,
    output logic                         RSTA,
    output logic [10:0]                  ADDRB,
    output logic                         ENB,
    output logic                         WEB,
    output logic                         RSTB,
    input  logic [1:0]                   DOB
);

    localparam logic [12:0] DEPTH    = 13'd4096;
    localparam logic [12:0] AF_LEVEL = 13'(AFULL_THRESH);
    localparam logic [12:0] AE_LEVEL = 13'(AEMPTY_THRESH);

    logic [11:0] wptr;
    logic [10:0] rptr;
    logic [12:0] level_q;
    logic        rd_valid_q;
    logic        ovf_q;
    logic        unf_q;

    logic        clr;
    logic        readable;
    logic        wr_ok;
    logic        rd_ok;
    logic [12:0] level_nxt;

    // RST and FLUSH give the same controller state; only RSTB differs.
    assign clr = RST | FLUSH;

    // A lone trailing bit is never read: a symbol needs two committed bits.
    assign readable = |level_q[12:1];

    assign FULL  = (level_q == DEPTH);
    assign EMPTY = (level_q == 13'd0);

    assign ALMOST_FULL  = (level_q >= AF_LEVEL);
    assign ALMOST_EMPTY = (level_q <= AE_LEVEL);

    assign wr_ok = host.WR_EN  & ~FULL     & ~clr;
    assign rd_ok = host.RD_REQ & readable  & ~clr;

    // Concurrent read+write nets -1; the read was checked against the
    // pre-write level, so it never touches a bit written this cycle.
    assign level_nxt = level_q
                     + {12'd0, wr_ok}
                     - {11'd0, rd_ok, 1'b0};

    // Port A: serial write side.
    assign ADDRA = wptr;
    assign DIA   = host.WR_DATA;
    assign ENA   = wr_ok;
    assign WEA   = wr_ok;
    assign RSTA  = 1'b0;

    // Port B: read-only pair side; enabling it during RST clears DOB.
    assign ADDRB = rptr;
    assign WEB   = 1'b0;
    assign ENB   = rd_ok | RST;
    assign RSTB  = RST;

    assign host.RD_DATA  = DOB;
    assign host.RD_VALID = rd_valid_q;

    assign LEVEL     = level_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

    always_ff @(posedge CLK) begin
        if (clr) begin
            wptr       <= '0;
            rptr       <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 12'd1;
            end
            if (rd_ok) begin
                rptr <= rptr + 11'd1;
            end
            level_q    <= level_nxt;
            rd_valid_q <= rd_ok;
            ovf_q      <= ovf_q | (host.WR_EN & FULL);
            unf_q      <= unf_q | (host.RD_REQ & ~readable);
        end
    end

    // The write pointer always sits LEVEL bits past the read pair address.
    a_ptr_invariant : assert property (
        @(posedge CLK) disable iff (RST)
        wptr == ({rptr, 1'b0} + level_q[11:0])
    );

endmodule

// File: tb/tb_ramb4_s1_s2_fifo_ctrl.sv
// Self-checking bench for ramb4_s1_s2_fifo_ctrl with a behavioural RAM
// and a bit-queue reference model of the FIFO.
module tb_ramb4_s1_s2_fifo_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        full, empty, afull, aempty;
    logic        ovf, unf;
    logic [12:0] level;
    logic [11:0] addra;
    logic        dia, ena, wea, rsta;
    logic [10:0] addrb;
    logic        enb, web, rstb;
    logic [1:0]  dob;

    int checks = 0;
    int errors = 0;

    ramb4_s1_s2_fifo_ctrl_if hif ();

    ramb4_s1_s2_fifo_ctrl #(
        .AFULL_THRESH (4032),
        .AEMPTY_THRESH(2)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .FLUSH       (flush),
        .host        (hif.slave),
        .FULL        (full),
        .EMPTY       (empty),
        .ALMOST_FULL (afull),
        .ALMOST_EMPTY(aempty),
        .OVERFLOW    (ovf),
        .UNDERFLOW   (unf),
        .LEVEL       (level),
        .ADDRA       (addra),
        .DIA         (dia),
        .ENA         (ena),
        .WEA         (wea),
        .RSTA        (rsta),
        .ADDRB       (addrb),
        .ENB         (enb),
        .WEB         (web),
        .RSTB        (rstb),
        .DOB         (dob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural X_RAMB4_S1_S2: bit address on A, pair address on B.
    logic mem [0:4095];
    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dia;
        if (enb) begin
            if (rstb) dob <= 2'b00;
            else dob <= {mem[{addrb, 1'b1}], mem[{addrb, 1'b0}]};
        end
    end

    // Reference model: FIFO of bits plus expected pointers and flags.
    bit       q[$];
    bit       m_ovf, m_unf, m_vld;
    logic [1:0] m_data;
    int       m_wa, m_ra;

    task automatic tick(input logic we, input logic wd, input logic rr,
                        input logic fl, input logic rs);
        bit wok, rok;
        int n;
        hif.WR_EN   = we;
        hif.WR_DATA = wd;
        hif.RD_REQ  = rr;
        flush       = fl;
        rst         = rs;
        n   = q.size();
        wok = we && n < 4096 && !rs && !fl;
        rok = rr && n >= 2 && !rs && !fl;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_vld = 0;
            m_wa = 0;  m_ra = 0;
            if (rs) m_data = 2'b00;
        end else begin
            if (we && n == 4096) m_ovf = 1;
            if (rr && n < 2) m_unf = 1;
            m_vld = rok;
            if (rok) begin
                m_data = {q[1], q[0]};
                void'(q.pop_front());
                void'(q.pop_front());
                m_ra = (m_ra + 1) % 2048;
            end
            if (wok) begin
                q.push_back(wd);
                m_wa = (m_wa + 1) % 4096;
            end
        end
    endtask

    task automatic test_reset();
        tick(1, 1, 1, 0, 1);
        tick(1, 1, 1, 0, 1);
        checks++;
        if (level !== 13'd0 || empty !== 1'b1 || aempty !== 1'b1 ||
            full !== 1'b0 || afull !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got lvl=%0d e=%b ae=%b f=%b af=%b req 0 1 1 0 0",
                     level, empty, aempty, full, afull);
        end
        checks++;
        if (hif.RD_VALID !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0 ||
            hif.RD_DATA !== 2'b00) begin
            errors++;
            $display("FAIL reset_out: got vld=%b ovf=%b unf=%b data=%b req 0 0 0 00",
                     hif.RD_VALID, ovf, unf, hif.RD_DATA);
        end
        checks++;
        if (rsta !== 1'b0 || web !== 1'b0 || rstb !== 1'b1 || enb !== 1'b1) begin
            errors++;
            $display("FAIL reset_ram: got rsta=%b web=%b rstb=%b enb=%b req 0 0 1 1",
                     rsta, web, rstb, enb);
        end
    endtask

    task automatic test_order();
        logic [5:0] bits;
        logic [1:0] exp_sym [3];
        bits = 6'b001101;
        exp_sym[0] = 2'b01;
        exp_sym[1] = 2'b11;
        exp_sym[2] = 2'b00;
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick(1, bits[i], 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0);
            checks++;
            if (hif.RD_VALID !== 1'b1 || hif.RD_DATA !== exp_sym[i]) begin
                errors++;
                $display("FAIL order_sym%0d: got vld=%b data=%b req 1 %b",
                         i, hif.RD_VALID, hif.RD_DATA, exp_sym[i]);
            end
        end
        checks++;
        if (level !== 13'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL order_end: got lvl=%0d empty=%b req 0 1", level, empty);
        end
    endtask

    task automatic test_full();
        int bad;
        tick(0, 0, 0, 0, 1);
        bad = 0;
        for (int n = 1; n <= 4096; n++) begin
            tick(1, 1'($urandom), 0, 0, 0);
            if (level !== 13'(n) || afull !== (n >= 4032) ||
                full !== (n == 4096)) begin
                if (bad < 4)
                    $display("FAIL fill_%0d: got lvl=%0d af=%b f=%b req %0d %b %b",
                             n, level, afull, full, n, n >= 4032, n == 4096);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        tick(1, 1, 0, 0, 0);
        checks++;
        if (ovf !== 1'b1 || level !== 13'd4096 || addra !== 12'd0) begin
            errors++;
            $display("FAIL overflow: got ovf=%b lvl=%0d addra=%0d req 1 4096 0",
                     ovf, level, addra);
        end
    endtask

    task automatic test_underflow();
        tick(0, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        checks++;
        if (hif.RD_VALID !== 1'b0 || unf !== 1'b1 || level !== 13'd1) begin
            errors++;
            $display("FAIL underflow: got vld=%b unf=%b lvl=%0d req 0 1 1",
                     hif.RD_VALID, unf, level);
        end
    endtask

    task automatic test_wrap();
        int bad;
        for (int i = 0; i < 4000 - 1; i++) tick(1, 1'($urandom), 0, 0, 0);
        checks++;
        if (level !== 13'd4000) begin
            errors++;
            $display("FAIL wrap_fill: got lvl=%0d req 4000", level);
        end
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            tick(1, 1'($urandom), 1, 0, 0);
            if (hif.RD_VALID !== 1'b1 || hif.RD_DATA !== m_data ||
                level !== 13'(4000 - 1 - i)) begin
                if (bad < 4)
                    $display("FAIL wrap_%0d: got vld=%b data=%b lvl=%0d req 1 %b %0d",
                             i, hif.RD_VALID, hif.RD_DATA, level, m_data, 3999 - i);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (addra !== 12'(m_wa) || addrb !== 11'(m_ra)) begin
            errors++;
            $display("FAIL wrap_ptr: got addra=%0d addrb=%0d req %0d %0d",
                     addra, addrb, m_wa, m_ra);
        end
    endtask

    task automatic test_flush();
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 4097; i++) tick(1, 1'($urandom), 0, 0, 0);
        for (int i = 0; i < 1998; i++) tick(0, 0, 1, 0, 0);
        checks++;
        if (level !== 13'd100 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: got lvl=%0d ovf=%b req 100 1", level, ovf);
        end
        tick(1, 1, 1, 1, 0);
        checks++;
        if (level !== 13'd0 || ovf !== 1'b0 || hif.RD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL flush: got lvl=%0d ovf=%b vld=%b req 0 0 0",
                     level, ovf, hif.RD_VALID);
        end
        flush       = 1'b0;
        hif.WR_EN   = 1'b1;
        hif.RD_REQ  = 1'b0;
        #1;
        checks++;
        if (addra !== 12'd0 || ena !== 1'b1 || wea !== 1'b1) begin
            errors++;
            $display("FAIL flush_wr: got addra=%0d ena=%b wea=%b req 0 1 1",
                     addra, ena, wea);
        end
        tick(1, 1, 0, 0, 0);
    endtask

    task automatic test_rst_midburst();
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        checks++;
        if (hif.RD_VALID !== 1'b1 || hif.RD_DATA !== 2'b11) begin
            errors++;
            $display("FAIL midburst_rd: got vld=%b data=%b req 1 11",
                     hif.RD_VALID, hif.RD_DATA);
        end
        tick(0, 0, 1, 0, 1);
        checks++;
        if (hif.RD_VALID !== 1'b0 || hif.RD_DATA !== 2'b00 || level !== 13'd0) begin
            errors++;
            $display("FAIL midburst_rst: got vld=%b data=%b lvl=%0d req 0 00 0",
                     hif.RD_VALID, hif.RD_DATA, level);
        end
    endtask

    task automatic test_random();
        int bad;
        int wp;
        int sz;
        logic we, rr, fl, rs;
        tick(0, 0, 0, 0, 1);
        bad = 0;
        for (int i = 0; i < 12000; i++) begin
            // Sweep write bias so the run visits both near-empty and full.
            wp = ((i / 3000) % 2 == 0) ? 90 : 25;
            we = ($urandom_range(0, 99) < wp);
            rr = ($urandom_range(0, 99) < 50);
            fl = ($urandom_range(0, 2999) == 0);
            rs = ($urandom_range(0, 4999) == 0);
            tick(we, 1'($urandom), rr, fl, rs);
            sz = q.size();
            if (level !== 13'(sz) || full !== (sz == 4096) ||
                empty !== (sz == 0) || afull !== (sz >= 4032) ||
                aempty !== (sz <= 2) || ovf !== m_ovf || unf !== m_unf ||
                hif.RD_VALID !== m_vld ||
                (m_vld && hif.RD_DATA !== m_data) ||
                addra !== 12'(m_wa) || addrb !== 11'(m_ra)) begin
                if (bad < 4)
                    $display("FAIL rand_%0d: got lvl=%0d ovf=%b unf=%b vld=%b data=%b wa=%0d ra=%0d req %0d %b %b %b %b %0d %0d",
                             i, level, ovf, unf, hif.RD_VALID, hif.RD_DATA,
                             addra, addrb, sz, m_ovf, m_unf, m_vld, m_data,
                             m_wa, m_ra);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        hif.WR_EN   = 1'b0;
        hif.WR_DATA = 1'b0;
        hif.RD_REQ  = 1'b0;
        m_data      = 2'b00;
        test_reset();
        test_order();
        test_full();
        test_underflow();
        test_wrap();
        test_flush();
        test_rst_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
